// File: rtl/easy6502_bus.sv
// easy6502 memory-bus front end.
// Shares the single 2 KiB RAM port between the 6502 core and the VGA screen
// reader, pausing the core only on an opcode fetch, and decodes the two
// easy6502 I/O bytes: random ($FE) and last key ($FF).
module easy6502_bus #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [15:0] RND_ADDR   = 16'h00FE,
  parameter logic [15:0] KEY_ADDR   = 16'h00FF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            cpu_do,
  input  logic                  cpu_we,
  input  logic                  cpu_sync,
  output logic                  cpu_rdy,
  output logic [7:0]            cpu_di,
  input  logic                  scr_req,
  input  logic [ADDR_WIDTH-1:0] scr_addr,
  output logic                  scr_grant,
  output logic [7:0]            scr_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout,
  input  logic                  key_valid,
  input  logic [7:0]            key_code
);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_SCR  = 2'd2;

  localparam logic [1:0] IO_NONE = 2'd0;
  localparam logic [1:0] IO_RND  = 2'd1;
  localparam logic [1:0] IO_KEY  = 2'd2;

  logic [1:0] state, state_nxt;
  logic [1:0] io_sel_q;
  logic [7:0] rnd_q, key_q, lfsr;
  logic       is_rnd, is_key, cpu_wr;

  // Next-state: the screen only takes the port on an opcode fetch, so a
  // request that drops before SYNC never pauses the core.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: state_nxt = scr_req ? ST_SCR : ST_CPU;
      ST_CPU:  if (scr_req && cpu_sync) state_nxt = ST_SCR;
      ST_SCR:  if (!scr_req) state_nxt = ST_CPU;
      default: state_nxt = ST_HOLD;
    endcase
  end

  // State register; reset forces HOLD so grant/rdy/we drop immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_HOLD;
    else        state <= state_nxt;
  end

  assign cpu_rdy   = (state == ST_CPU);
  assign scr_grant = (state == ST_SCR);

  assign is_rnd = (cpu_addr == RND_ADDR);
  assign is_key = (cpu_addr == KEY_ADDR);
  assign cpu_wr = cpu_we && cpu_rdy;

  assign ram_addr = scr_grant ? scr_addr : cpu_addr[ADDR_WIDTH-1:0];
  assign ram_we   = cpu_wr && !is_rnd && !is_key;
  assign ram_din  = cpu_do;
  assign scr_data = ram_dout;

  // Last-key register; a fresh keystroke beats a simultaneous CPU write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                key_q <= 8'h00;
    else if (key_valid)        key_q <= key_code;
    else if (cpu_wr && is_key) key_q <= cpu_do;
  end

  // Free-running Galois LFSR (mask B8, maximal length, never zero).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       lfsr <= LFSR_SEED;
    else if (lfsr[0]) lfsr <= {1'b0, lfsr[7:1]} ^ 8'hB8;
    else              lfsr <= {1'b0, lfsr[7:1]};
  end

  // Register the I/O decode and random snapshot so reads line up with
  // the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_sel_q <= IO_NONE;
      rnd_q    <= 8'h00;
    end else if (cpu_rdy) begin
      io_sel_q <= is_rnd ? IO_RND : (is_key ? IO_KEY : IO_NONE);
      rnd_q    <= lfsr;
    end else begin
      io_sel_q <= IO_NONE;
    end
  end

  // CPU read mux; held at zero while in HOLD (reset and the cycle after).
  always_comb begin
    cpu_di = ram_dout;
    if (state == ST_HOLD)        cpu_di = 8'h00;
    else if (io_sel_q == IO_RND) cpu_di = rnd_q;
    else if (io_sel_q == IO_KEY) cpu_di = key_q;
  end

endmodule

// File: tb/tb_easy6502_bus.sv
// Bench for easy6502_bus: directed stimulus, a behavioural bus model
// checked every cycle, plus hand-computed literal expectations.
module tb_easy6502_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic        cpu_we, cpu_sync;
  logic        cpu_rdy;
  logic [7:0]  cpu_di;
  logic        scr_req;
  logic [10:0] scr_addr;
  logic        scr_grant;
  logic [7:0]  scr_data;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        key_valid;
  logic [7:0]  key_code;

  int checks = 0;
  int errors = 0;

  easy6502_bus dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_do(cpu_do),
    .cpu_we(cpu_we), .cpu_sync(cpu_sync), .cpu_rdy(cpu_rdy), .cpu_di(cpu_di),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_grant(scr_grant),
    .scr_data(scr_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .key_valid(key_valid),
    .key_code(key_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM attached to the DUT: synchronous read, one-cycle latency.
  logic [7:0] mem [2048];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- behavioural model ----------------
  logic [7:0] tbl [255];       // LFSR sequence, tbl[0] = seed
  logic [7:0] m_mem [2048];
  logic [7:0] m_dout;
  logic       m_run, m_grant, m_grant_d;
  int         m_idx;
  logic [1:0] m_io;            // 0 RAM, 1 random, 2 key
  logic [7:0] m_rnd, m_key;
  logic [10:0] exp_addr;
  logic        exp_we;
  logic [7:0]  exp_di;

  always_comb begin
    exp_addr = m_grant ? scr_addr : cpu_addr[10:0];
    exp_we   = m_run && cpu_we && cpu_addr != 16'h00FE && cpu_addr != 16'h00FF;
    if (!m_run && !m_grant) exp_di = 8'h00;
    else if (m_io == 2'd1)  exp_di = m_rnd;
    else if (m_io == 2'd2)  exp_di = m_key;
    else                    exp_di = m_dout;
  end

  always @(posedge clk) begin
    if (exp_we) m_mem[exp_addr] <= cpu_do;
    m_dout <= m_mem[exp_addr];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0; m_grant <= 1'b0; m_grant_d <= 1'b0; m_idx <= 0;
      m_io <= 2'd0; m_rnd <= 8'h00; m_key <= 8'h00;
    end else begin
      m_grant_d <= m_grant;
      m_idx     <= (m_idx + 1) % 255;
      if (!m_run && !m_grant) begin
        m_grant <= scr_req; m_run <= !scr_req;
      end else if (m_run && scr_req && cpu_sync) begin
        m_run <= 1'b0; m_grant <= 1'b1;
      end else if (m_grant && !scr_req) begin
        m_grant <= 1'b0; m_run <= 1'b1;
      end
      if (m_run) begin
        m_io  <= (cpu_addr == 16'h00FE) ? 2'd1 : (cpu_addr == 16'h00FF) ? 2'd2 : 2'd0;
        m_rnd <= tbl[m_idx];
      end else begin
        m_io <= 2'd0;
      end
      if (key_valid) m_key <= key_code;
      else if (m_run && cpu_we && cpu_addr == 16'h00FF) m_key <= cpu_do;
    end
  end

  // Compare process: outputs are settled mid-cycle.
  always @(negedge clk) begin
    chk("cpu_rdy",   32'(cpu_rdy),   32'(m_run));
    chk("scr_grant", 32'(scr_grant), 32'(m_grant));
    chk("ram_addr",  32'(ram_addr),  32'(exp_addr));
    chk("ram_we",    32'(ram_we),    32'(exp_we));
    chk("ram_din",   32'(ram_din),   32'(cpu_do));
    chk("cpu_di",    32'(cpu_di),    32'(exp_di));
    if (m_grant_d) chk("scr_data", 32'(scr_data), 32'(m_dout));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] v1, v2, nx;

  initial begin
    tbl[0] = 8'hA5;
    for (int i = 1; i < 255; i++) begin
      nx = {1'b0, tbl[i-1][7:1]};
      tbl[i] = tbl[i-1][0] ? (nx ^ 8'hB8) : nx;
    end
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'(i) ^ 8'h3C;
      m_mem[i] = 8'(i) ^ 8'h3C;
    end
    mem[11'h200] = 8'h05; m_mem[11'h200] = 8'h05;

    reset = 1'b0; cpu_addr = 16'h00FE; cpu_do = 8'h00; cpu_we = 1'b0;
    cpu_sync = 1'b0; scr_req = 1'b0; scr_addr = 11'h000;
    key_valid = 1'b0; key_code = 8'h00;
    cyc(3);
    chk("reset_rdy",   32'(cpu_rdy),   32'd0);
    chk("reset_grant", 32'(scr_grant), 32'd0);
    chk("reset_di",    32'(cpu_di),    32'd0);

    // Release; CPU runs from the first edge, reading $FE every cycle.
    reset = 1'b1;
    cyc(1);
    chk("rdy_after_reset", 32'(cpu_rdy), 32'd1);
    cyc(1); chk("rnd_0", 32'(cpu_di), 32'hEA);
    cyc(1); chk("rnd_1", 32'(cpu_di), 32'h75);
    cyc(1); chk("rnd_2", 32'(cpu_di), 32'h82);
    cyc(256);   // full LFSR period plus wrap, checked by the model

    // Aliased addresses and a RAM write through the alias.
    for (int i = 0; i < 16; i++) begin
      cpu_addr = 16'h1000 + 16'(i * 73);
      cyc(1);
    end
    cpu_addr = 16'h1234; cpu_do = 8'h3C; cpu_we = 1'b1;
    #1 chk("alias_we", 32'(ram_we), 32'd1);
    cyc(1); cpu_we = 1'b0; cpu_addr = 16'h0234;
    cyc(2); chk("alias_read", 32'(cpu_di), 32'h3C);

    // Request that drops before SYNC: CPU never paused.
    scr_req = 1'b1; scr_addr = 11'h200;
    cyc(2); scr_req = 1'b0;
    cyc(2); chk("cancel_rdy", 32'(cpu_rdy), 32'd1);

    // Mid-instruction request drained until SYNC.
    cpu_addr = 16'h0150; scr_req = 1'b1;
    cyc(1); chk("drain_rdy0", 32'(cpu_rdy), 32'd1);
    cyc(1); chk("drain_rdy1", 32'(cpu_rdy), 32'd1);
    cyc(1); chk("drain_rdy2", 32'(cpu_rdy), 32'd1);
    cpu_sync = 1'b1;
    cyc(1); cpu_sync = 1'b0;
    chk("pause_rdy",   32'(cpu_rdy),   32'd0);
    chk("pause_grant", 32'(scr_grant), 32'd1);
    chk("pause_addr",  32'(ram_addr),  32'h200);
    cyc(1); chk("scr_data_200", 32'(scr_data), 32'h05);
    scr_req = 1'b0;
    cyc(1);
    chk("resume_rdy",  32'(cpu_rdy),  32'd1);
    chk("resume_addr", 32'(ram_addr), 32'h150);
    cyc(2); chk("resume_read", 32'(cpu_di), 32'(8'h50 ^ 8'h3C));

    // Two random reads ten cycles apart; writes to $FE are dropped.
    cpu_addr = 16'h00FE;
    cyc(1); v1 = cpu_di;
    cpu_addr = 16'h0010;
    cyc(9); cpu_addr = 16'h00FE;
    cyc(1); v2 = cpu_di;
    chk("rnd_differ",  32'(v1 != v2),     32'd1);
    chk("rnd_nonzero", 32'(v1 != 0 && v2 != 0), 32'd1);
    cpu_do = 8'h99; cpu_we = 1'b1;
    #1 chk("rnd_write_we", 32'(ram_we), 32'd0);
    cyc(1); cpu_we = 1'b0; cpu_addr = 16'h08FE;
    cyc(2); chk("ram_0fe_kept", 32'(cpu_di), 32'hC2);

    // Key register.
    key_valid = 1'b1; key_code = 8'h77;
    cyc(1); key_valid = 1'b0; cpu_addr = 16'h00FF;
    cyc(1); chk("key_77", 32'(cpu_di), 32'h77);
    cpu_do = 8'h00; cpu_we = 1'b1;
    #1 chk("key_write_we", 32'(ram_we), 32'd0);
    cyc(1); cpu_we = 1'b0;
    cyc(1); chk("key_cpu_00", 32'(cpu_di), 32'h00);
    key_valid = 1'b1; key_code = 8'h64; cpu_we = 1'b1; cpu_do = 8'h00;
    #1 chk("key_both_we", 32'(ram_we), 32'd0);
    cyc(1); key_valid = 1'b0; cpu_we = 1'b0;
    cyc(1); chk("key_both_64", 32'(cpu_di), 32'h64);

    // Async reset while the screen owns the port.
    scr_req = 1'b1; cpu_sync = 1'b1;
    cyc(2); cpu_sync = 1'b0;
    chk("pre_reset_grant", 32'(scr_grant), 32'd1);
    cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_do = 8'hEE;
    #2 reset = 1'b0;
    #1;
    chk("async_grant", 32'(scr_grant), 32'd0);
    chk("async_rdy",   32'(cpu_rdy),   32'd0);
    chk("async_we",    32'(ram_we),    32'd0);
    scr_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h00FF;
    cyc(2);
    reset = 1'b1;
    cyc(1); chk("hold_then_run", 32'(cpu_rdy), 32'd1);
    cyc(1); chk("key_cleared", 32'(cpu_di), 32'h00);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/easy6502_bus.md
Name: easy6502_bus

Overview:
- Memory-bus front end between the 6502 core, the shared 2 KiB system RAM and the VGA screen reader.
- Arbitrates the single RAM port: the screen reader owns it while it requests; the CPU owns it otherwise.
- The CPU is paused only on an instruction boundary (SYNC).
- Also decodes the easy6502 memory-mapped I/O: a free-running random byte at $FE and the last key pressed at $FF.

Parameters:
- ADDR_WIDTH, 11: RAM address width; CPU address bits above it alias.
- LFSR_SEED, 8'hA5: random-generator reset value; must be non-zero.
- RND_ADDR, 16'h00FE: address of the random-byte register (read-only).
- KEY_ADDR, 16'h00FF: address of the last-key register (read/write).

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- cpu_addr  in  16  CPU address bus (combinatorial from core)
- cpu_do  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_sync  in  1  CPU is fetching an opcode this cycle
- cpu_rdy  out  1  CPU RDY; 0 pauses the core
- cpu_di  out  8  CPU read data
- scr_req  in  1  screen reader requests the RAM port
- scr_addr  in  ADDR_WIDTH  screen read address
- scr_grant  out  1  screen reader owns the RAM port
- scr_data  out  8  screen read data
- ram_addr  out  ADDR_WIDTH  RAM read/write address
- ram_we  out  1  RAM write enable
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data; registered, 1-cycle latency
- key_valid  in  1  one-cycle strobe: new key code available
- key_code  in  8  ASCII key code, valid with key_valid

Behaviour:
- Reset (reset=0, async): state=HOLD; cpu_rdy=0, scr_grant=0, ram_we=0, cpu_di=0; key register=0; LFSR=LFSR_SEED; io_sel_q=NONE.
- FSM states:
  - HOLD: go to SCREEN if scr_req, else CPU_RUN.
  - CPU_RUN: go to SCREEN if scr_req && cpu_sync; stay otherwise. A request mid-instruction is drained until the next SYNC.
  - SCREEN: go to CPU_RUN when scr_req=0.
- Registered outputs:
  - cpu_rdy = (state==CPU_RUN).
  - scr_grant = (state==SCREEN).
- Port mux, combinational on state:
  - SCREEN: ram_addr = scr_addr.
  - Otherwise: ram_addr = cpu_addr[ADDR_WIDTH-1:0]. Addresses >= 2^ADDR_WIDTH alias into RAM.
- ram_din = cpu_do.
- ram_we = cpu_we && state==CPU_RUN && cpu_addr not in {RND_ADDR, KEY_ADDR}. I/O addresses use full 16-bit compare.
- Writes to I/O addresses:
  - Write to KEY_ADDR in CPU_RUN loads the key register from cpu_do.
  - Write to RND_ADDR is ignored.
- Key register:
  - key_valid loads key_code.
  - key_valid and a CPU write to KEY_ADDR in the same cycle: key_valid wins.
- LFSR: 8-bit Galois, mask 8'hB8, shifts every cycle including while the CPU is paused; never reaches 0.
- CPU read path (1-cycle latency, matching the core's synchronous-RAM timing):
  - io_sel_q is captured each cycle from cpu_addr when state==CPU_RUN: RND, KEY or NONE.
  - The LFSR value is snapshotted into rnd_q on the same edge.
  - cpu_di = rnd_q if io_sel_q==RND; key register if KEY; ram_dout otherwise.
- Screen read path:
  - scr_data = ram_dout.
  - Valid the cycle after scr_addr is presented while scr_grant=1.
  - The first valid datum follows the first granted address cycle.
  - The screen reader must ignore data until scr_grant has been 1 for one cycle.
- While paused: the CPU holds its address. On resume, cpu_di shows stale ram_dout for one cycle; the core ignores DI while RDY=0, so this is harmless.
- Reset asserted in SCREEN or CPU_RUN: immediately HOLD; no RAM write occurs in that cycle.
- scr_req dropping in CPU_RUN before the SYNC seen: the request is cancelled and the CPU is never paused.

Test Plan:
- Reset release with scr_req=0 → cpu_rdy=1 one cycle after reset rises; ram_addr tracks cpu_addr[10:0]; LFSR sequence from 8'hA5 matches the reference model for 255 cycles, then repeats.
- CPU executing, scr_req raised mid-instruction (sync=0 for 3 cycles, then 1) → cpu_rdy stays 1 for those 3 cycles; falls the cycle after sync=1; scr_grant=1 at that edge; ram_addr=scr_addr.
- Screen owns the port; scr_addr=0x200 where RAM[0x200]=0x05 → scr_data=0x05 one cycle later. Deassert scr_req → CPU_RUN next cycle; CPU resumes at the held address.
- CPU reads $FE twice, 10 cycles apart → cpu_di equals the LFSR snapshot at each address cycle; the two values differ and are non-zero. RAM[0x0FE] is unchanged by a write to $FE.
- key_valid with key_code=0x77 → a later read of $FF returns 0x77. CPU write 0x00 to $FF → read returns 0x00. Simultaneous key_valid (0x64) and CPU write (0x00) → register=0x64. ram_we stays 0 throughout.
- Reset pulled low while in SCREEN with cpu_we=1 → scr_grant, cpu_rdy and ram_we go 0 asynchronously; key register=0; after release the FSM goes through HOLD.
